// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for the N-way selector: N producer channels in, one registered consumer channel out.
// The master side drives the producer inputs and the consumer ready; the slave side is the selector.
interface mux_sel_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SELW  = 2
);
    localparam int N = 2 ** SELW;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered N-way selector with valid/ready on every channel: explicit select (MODE 0)
// or round-robin arbitration (MODE 1), one output register sustaining one word per cycle.
module mux_sel_pipe #(
    parameter int WIDTH = 32,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic           clk,
    input  logic           reset,
    mux_sel_pipe_if.slave  bus
);
    localparam int N = 2 ** SELW;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  idx;
    logic             req;
    logic             can_load;
    logic             xfer;

    // Round-robin scan runs from the far end back to rr_ptr so the closest requester wins last.
    always_comb begin
        gnt = '0;
        req = 1'b0;
        idx = '0;
        if (MODE == 0) begin
            gnt = bus.sel;
            req = bus.in_valid[bus.sel];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = rr_ptr_q + SELW'(k);
                if (bus.in_valid[idx]) begin
                    gnt = idx;
                    req = 1'b1;
                end
            end
        end
    end

    assign can_load = ~out_valid_q | bus.out_ready;
    assign xfer     = can_load & req & ~reset;

    assign bus.in_ready = xfer ? (N'(1) << gnt) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = bus.in_data[int'(gnt) * WIDTH +: WIDTH];
            out_src_d   = gnt;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                rr_ptr_d = gnt + SELW'(1);
            end
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered N-way selector with valid/ready handshaking on every input and on the output; the next generation of the datapath muxes.
- Two modes, chosen by parameter:
  - MODE 0: explicit select.
  - MODE 1: round-robin arbitration among valid requesters.
- Used where several producers (e.g. writeback sources, memory requesters) share one consumer that can stall.

Parameters:
- WIDTH, 32, data width of each channel.
- SELW, 2, select width; channel count N = 2**SELW (2..16 supported, SELW 1..4).
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has a word.
- in_ready  output  N  channel i word is consumed this cycle when in_valid[i] & in_ready[i].
- sel  input  SELW  channel choice (MODE 0 only).
- out_data  output  WIDTH  registered selected word.
- out_src  output  SELW  index of the channel out_data came from.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts when out_valid & out_ready.

Behaviour:
- Reset, asynchronous, immediate:
  - out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0.
  - A word held in the output register at reset is discarded.
- Storage: one output register. Define can_load = ~out_valid | out_ready.
- Grant selection, combinational, at most one bit of grant set:
  - MODE 0: gnt = sel; request present iff in_valid[sel]. Other channels never see in_ready.
  - MODE 1: gnt = first i with in_valid[i] set, scanning rr_ptr, rr_ptr+1, ..., wrapping mod N. No request if in_valid is all 0.
- in_ready[i] = can_load & request present & (i == gnt). in_ready depends combinationally on in_valid/sel; producers must not make in_valid depend on in_ready.
- Transfer in (in_valid[gnt] & in_ready[gnt]), on that clk edge:
  - out_data <= in_data[gnt]; out_src <= gnt; out_valid <= 1.
  - MODE 1 only: rr_ptr <= (gnt + 1) mod N.
- Drain with no load (out_valid & out_ready & no transfer in): out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge; out_valid stays 1. Sustains 1 word/cycle.
- Stall (out_valid & ~out_ready):
  - All in_ready = 0.
  - out_data, out_src, out_valid and rr_ptr hold.
- Latency: input accepted at edge k appears on out_data after edge k (visible in cycle k+1).
- rr_ptr changes only on a transfer in. Idle cycles and stalls do not rotate priority.
- MODE 0: sel may change every cycle; only its value in the accepting cycle matters.
- Boundaries:
  - rr_ptr = N-1 wraps to 0 after a grant to N-1.
  - A single requester is granted back-to-back every cycle.
  - Requests and sel are ignored while reset is high.

Test Plan:
- Reset mid-transfer: WIDTH=32, SELW=2, MODE=0. Load ch2 = 0xDEADBEEF, hold out_ready=0, assert reset asynchronously between edges -> out_valid=0, out_data=0, out_src=0 immediately, without waiting for a clk edge.
- Select streaming, MODE 0, out_ready=1:
  - sel=1,3,0 on consecutive cycles; in_data ch0..3 = 0x10,0x11,0x12,0x13; all valid.
  - -> out_data 0x11,0x13,0x10 with out_src 1,3,0, each one cycle after acceptance.
  - in_ready is one-hot on the selected channel.
- Stall: out_valid=1 holding 0xAA from ch0, out_ready=0 for 3 cycles, ch1 valid -> in_ready=0000 all 3 cycles, out_data stays 0xAA. out_ready=1 -> ch1 word out next cycle.
- Round-robin fairness, MODE 1, all 4 in_valid=1, out_ready=1 continuous -> out_src sequence 0,1,2,3,0,1.
- Round-robin skip and wrap, MODE 1: rr_ptr=3 (after grants 0,1,2); requests only on ch1 and ch3 -> grant 3, then 1, then 3.
- Idle and drain, MODE 1: no in_valid for 5 cycles after a ch2 grant -> out_valid drops after one out_ready cycle; rr_ptr stays 3; next request on ch0 only -> ch0 granted.
